// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/DMA arbiter for a single memory bus port; optional starve guard via MEM_ARB_STARVE_GUARD_EN
module mem_bus_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  output logic [31:0] cpu_rdata,
  output logic        cpu_pause,
  input  logic        dma_req,
  input  logic        dma_write,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [1:0]  dma_size,
  output logic [31:0] dma_rdata,
  output logic        dma_pause,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_pause,
  output logic        owner
);

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    DMA_OWN = 2'd1,
    WR_HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   hold_owner_q, hold_owner_d;
  logic   rd_owner_q;
  logic   owner_cur;
  logic   owner_write;
  logic   in_hold;
  logic   write_now;
  logic   owner_pause;
  logic   starve_force;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Count consecutive DMA_OWN cycles, saturating at 15; any other state clears it.
  always_comb begin
    starve_cnt_d = 4'd0;
    if (state_q == DMA_OWN) begin
      starve_cnt_d = (starve_cnt_q == 4'd15) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
  end

  // Starve counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_force = (starve_cnt_q == 4'd15) && cpu_req;
`else
  assign starve_force = 1'b0;
`endif

  // Resolve who owns the bus this cycle and whether that owner is writing.
  always_comb begin
    in_hold     = (state_q == WR_HOLD);
    owner_cur   = in_hold ? hold_owner_q : (state_q == DMA_OWN);
    owner_write = owner_cur ? (dma_write & dma_req) : (cpu_write & cpu_req);
    write_now   = ~in_hold & owner_write;
    owner_pause = mem_pause | in_hold;
  end

  // Bus muxing, pause and read-data steering; reset forces the quiet values.
  always_comb begin
    owner     = owner_cur & ~reset;
    mem_addr  = owner_cur ? dma_addr  : cpu_addr;
    mem_wdata = owner_cur ? dma_wdata : cpu_wdata;
    mem_size  = owner_cur ? dma_size  : cpu_size;
    mem_write = write_now & ~reset;
    cpu_pause = 1'b0;
    dma_pause = dma_req;
    if (!reset) begin
      cpu_pause = owner_cur ? cpu_req : owner_pause;
      dma_pause = owner_cur ? owner_pause : dma_req;
    end
    cpu_rdata = (!reset && !rd_owner_q) ? mem_rdata : 32'h0;
    dma_rdata = (!reset &&  rd_owner_q) ? mem_rdata : 32'h0;
  end

  // Next-state: a write always enters WR_HOLD first; switches are judged only outside the hold.
  always_comb begin
    state_d      = state_q;
    hold_owner_d = hold_owner_q;
    case (state_q)
      CPU_OWN: begin
        if (write_now) begin
          state_d      = WR_HOLD;
          hold_owner_d = 1'b0;
        end else if (dma_req) begin
          state_d = DMA_OWN;
        end
      end
      DMA_OWN: begin
        if (write_now) begin
          state_d      = WR_HOLD;
          hold_owner_d = 1'b1;
        end else if (!dma_req || starve_force) begin
          state_d = CPU_OWN;
        end
      end
      WR_HOLD: begin
        if (!mem_pause) begin
          state_d = hold_owner_q ? DMA_OWN : CPU_OWN;
        end
      end
      default: begin
        state_d      = CPU_OWN;
        hold_owner_d = 1'b0;
      end
    endcase
  end

  // State, hold owner and read-return owner registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= CPU_OWN;
      hold_owner_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_owner_q <= hold_owner_d;
      rd_owner_q   <= owner_cur;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter (honours MEM_ARB_STARVE_GUARD_EN)
module tb_mem_bus_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 0, cpu_write = 0, dma_req = 0, dma_write = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [1:0]  cpu_size = 0, dma_size = 0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic        cpu_pause, dma_pause, mem_write, owner;
  logic [1:0]  mem_size;
  logic        mem_pause = 0;

  int n_checks = 0;
  int n_pass   = 0;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_rdata(cpu_rdata), .cpu_pause(cpu_pause),
    .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_size(dma_size), .dma_rdata(dma_rdata), .dma_pause(dma_pause),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_pause(mem_pause), .owner(owner)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_write = 0; dma_req = 0; dma_write = 0;
    mem_pause = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cpu_req = 1; cpu_write = 1; dma_req = 1; mem_pause = 1; mem_rdata = 32'hDEAD_BEEF;
    #2 reset = 1'b1;
    #2;
    n_checks++; if (owner !== 1'b0) $display("FAIL rst_owner got=%b exp=0", owner); else n_pass++;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write got=%b exp=0", mem_write); else n_pass++;
    n_checks++; if (cpu_pause !== 1'b0) $display("FAIL rst_cpu_pause got=%b exp=0", cpu_pause); else n_pass++;
    n_checks++; if (dma_pause !== 1'b1) $display("FAIL rst_dma_pause got=%b exp=1", dma_pause); else n_pass++;
    n_checks++; if (cpu_rdata !== 32'h0) $display("FAIL rst_cpu_rdata got=%h exp=0", cpu_rdata); else n_pass++;
    n_checks++; if (dma_rdata !== 32'h0) $display("FAIL rst_dma_rdata got=%h exp=0", dma_rdata); else n_pass++;
    step();
    dma_req = 0;
    #1;
    n_checks++; if (dma_pause !== 1'b0) $display("FAIL rst_dma_pause_follow got=%b exp=0", dma_pause); else n_pass++;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write_edge got=%b exp=0", mem_write); else n_pass++;
    idle_inputs();
    reset = 1'b0;
    step();
  endtask

  task automatic test_cpu_read();
    logic [31:0] r;
    do_reset();
    r = $urandom;
    cpu_req = 1; cpu_write = 0; cpu_addr = 32'h0300_0010; cpu_size = 2'b10; dma_req = 0;
    #2;
    n_checks++; if (owner !== 1'b0) $display("FAIL rd_owner got=%b exp=0", owner); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0300_0010) $display("FAIL rd_mem_addr got=%h exp=03000010", mem_addr); else n_pass++;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL rd_mem_write got=%b exp=0", mem_write); else n_pass++;
    step();
    cpu_req = 0; mem_rdata = r;
    #2;
    n_checks++; if (cpu_rdata !== r) $display("FAIL rd_cpu_rdata got=%h exp=%h", cpu_rdata, r); else n_pass++;
    n_checks++; if (dma_rdata !== 32'h0) $display("FAIL rd_dma_rdata got=%h exp=0", dma_rdata); else n_pass++;
    step();
  endtask

  task automatic test_write_hold();
    do_reset();
    cpu_req = 1; cpu_write = 1; cpu_addr = 32'h0600_0000; cpu_size = 2'b10;
    cpu_wdata = $urandom; dma_req = 1; dma_write = 0; mem_pause = 0;
    #2;
    n_checks++; if (mem_write !== 1'b1) $display("FAIL wh_mem_write0 got=%b exp=1", mem_write); else n_pass++;
    n_checks++; if (owner !== 1'b0) $display("FAIL wh_owner0 got=%b exp=0", owner); else n_pass++;
    step();
    #1;
    n_checks++; if (cpu_pause !== 1'b1) $display("FAIL wh_cpu_pause got=%b exp=1", cpu_pause); else n_pass++;
    n_checks++; if (dma_pause !== 1'b1) $display("FAIL wh_dma_pause got=%b exp=1", dma_pause); else n_pass++;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL wh_mem_write1 got=%b exp=0", mem_write); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0600_0000) $display("FAIL wh_mem_addr got=%h exp=06000000", mem_addr); else n_pass++;
    n_checks++; if (mem_wdata !== cpu_wdata) $display("FAIL wh_mem_wdata got=%h exp=%h", mem_wdata, cpu_wdata); else n_pass++;
    step();
    cpu_req = 0; cpu_write = 0;
    #1;
    n_checks++; if (owner !== 1'b0) $display("FAIL wh_owner_exit got=%b exp=0", owner); else n_pass++;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL wh_no_replay got=%b exp=0", mem_write); else n_pass++;
    step();
    #1;
    n_checks++; if (owner !== 1'b1) $display("FAIL wh_owner_dma got=%b exp=1", owner); else n_pass++;
    n_checks++; if (dma_pause !== 1'b0) $display("FAIL wh_dma_pause_granted got=%b exp=0", dma_pause); else n_pass++;
    dma_req = 0;
    step();
  endtask

  task automatic test_both_req();
    do_reset();
    cpu_req = 1; dma_req = 1;
    #2;
    n_checks++; if (owner !== 1'b0) $display("FAIL both_owner0 got=%b exp=0", owner); else n_pass++;
    for (int i = 1; i <= 5; i++) begin
      step();
      #1;
      n_checks++; if (owner !== 1'b1) $display("FAIL both_owner c%0d got=%b exp=1", i, owner); else n_pass++;
      n_checks++; if (cpu_pause !== 1'b1) $display("FAIL both_cpu_pause c%0d got=%b exp=1", i, cpu_pause); else n_pass++;
    end
    dma_req = 0;
    #1;
    n_checks++; if (cpu_pause !== 1'b1) $display("FAIL both_cpu_pause_fall got=%b exp=1", cpu_pause); else n_pass++;
    step();
    #1;
    n_checks++; if (owner !== 1'b0) $display("FAIL both_owner_back got=%b exp=0", owner); else n_pass++;
    n_checks++; if (cpu_pause !== 1'b0) $display("FAIL both_cpu_pause_back got=%b exp=0", cpu_pause); else n_pass++;
    cpu_req = 0;
    step();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    dma_req = 1;
    step();
    dma_write = 1; dma_addr = 32'h0700_0040; dma_wdata = $urandom;
    #2;
    n_checks++; if (mem_write !== 1'b1) $display("FAIL rh_dma_write got=%b exp=1", mem_write); else n_pass++;
    step();
    mem_pause = 1;
    #1;
    n_checks++; if (owner !== 1'b1) $display("FAIL rh_hold_owner got=%b exp=1", owner); else n_pass++;
    n_checks++; if (dma_pause !== 1'b1) $display("FAIL rh_hold_pause got=%b exp=1", dma_pause); else n_pass++;
    step();
    reset = 1'b1;
    #1;
    n_checks++; if (owner !== 1'b0) $display("FAIL rh_rst_owner got=%b exp=0", owner); else n_pass++;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL rh_rst_mem_write got=%b exp=0", mem_write); else n_pass++;
    step();
    reset = 1'b0; mem_pause = 0; dma_write = 0;
    #1;
    n_checks++; if (owner !== 1'b0) $display("FAIL rh_post_owner got=%b exp=0", owner); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      n_checks++; if (mem_write !== 1'b0) $display("FAIL rh_replay c%0d got=%b exp=0", i, mem_write); else n_pass++;
      n_checks++; if (owner !== 1'b1) $display("FAIL rh_regrant c%0d got=%b exp=1", i, owner); else n_pass++;
    end
    dma_req = 0;
    step();
  endtask

  task automatic test_starve();
    logic e;
    do_reset();
    cpu_req = 1; dma_req = 1;
    #2;
    n_checks++; if (owner !== 1'b0) $display("FAIL starve_owner0 got=%b exp=0", owner); else n_pass++;
    for (int i = 1; i <= 18; i++) begin
      step();
      #1;
      e = (GUARD && i == 17) ? 1'b0 : 1'b1;
      n_checks++; if (owner !== e) $display("FAIL starve_owner c%0d got=%b exp=%b", i, owner, e); else n_pass++;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    bit m_dma, m_hold, m_who, m_rd, cur, e_mw, e_cp, e_dp;
    int m_run;
    logic [31:0] e_crd, e_drd;
    logic [65:0] e_bus;
    do_reset();
    m_dma = 0; m_hold = 0; m_who = 0; m_rd = 0; m_run = 0;
    for (int c = 0; c < 400; c++) begin
      cpu_req = ($urandom_range(0, 3) != 0); cpu_write = ($urandom_range(0, 3) == 0);
      dma_req = ($urandom_range(0, 3) != 0); dma_write = ($urandom_range(0, 4) == 0);
      cpu_addr = $urandom; cpu_wdata = $urandom; cpu_size = 2'($urandom_range(0, 2));
      dma_addr = $urandom; dma_wdata = $urandom; dma_size = 2'($urandom_range(0, 2));
      mem_pause = ($urandom_range(0, 2) == 0); mem_rdata = $urandom;
      cur   = m_hold ? m_who : m_dma;
      e_mw  = !m_hold && (cur ? (dma_req && dma_write) : (cpu_req && cpu_write));
      e_bus = cur ? {dma_addr, dma_wdata, dma_size} : {cpu_addr, cpu_wdata, cpu_size};
      e_cp  = cur ? cpu_req : (mem_pause || m_hold);
      e_dp  = cur ? (mem_pause || m_hold) : dma_req;
      e_crd = m_rd ? 32'h0 : mem_rdata;
      e_drd = m_rd ? mem_rdata : 32'h0;
      #2;
      n_checks++; if (owner !== cur) $display("FAIL rnd_owner c%0d got=%b exp=%b", c, owner, cur); else n_pass++;
      n_checks++; if (mem_write !== e_mw) $display("FAIL rnd_mem_write c%0d got=%b exp=%b", c, mem_write, e_mw); else n_pass++;
      n_checks++; if ({mem_addr, mem_wdata, mem_size} !== e_bus) $display("FAIL rnd_bus c%0d got=%h exp=%h", c, {mem_addr, mem_wdata, mem_size}, e_bus); else n_pass++;
      n_checks++; if (cpu_pause !== e_cp) $display("FAIL rnd_cpu_pause c%0d got=%b exp=%b", c, cpu_pause, e_cp); else n_pass++;
      n_checks++; if (dma_pause !== e_dp) $display("FAIL rnd_dma_pause c%0d got=%b exp=%b", c, dma_pause, e_dp); else n_pass++;
      n_checks++; if ({cpu_rdata, dma_rdata} !== {e_crd, e_drd}) $display("FAIL rnd_rdata c%0d got=%h/%h exp=%h/%h", c, cpu_rdata, dma_rdata, e_crd, e_drd); else n_pass++;
      step();
      m_rd = cur;
      if (m_hold) begin
        if (!mem_pause) m_hold = 0;
        m_run = 0;
      end else if (e_mw) begin
        m_hold = 1; m_who = cur; m_run = 0;
      end else if (!cur) begin
        if (dma_req) m_dma = 1;
        m_run = 0;
      end else begin
        if (!dma_req || (GUARD && m_run >= 15 && cpu_req)) m_dma = 0;
        m_run = m_run + 1;
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_write_hold();
    test_both_req();
    test_reset_mid_hold();
    test_starve();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have port: clock  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high.
REQ-003 SHALL have ports: cpu_req, cpu_write  input  1 each  CPU access request / write qualifier.
REQ-004 SHALL have ports: cpu_addr, cpu_wdata  input  32 each; cpu_size  input  2  (byte/half/word encoding of the memory system).
REQ-005 SHALL have ports: cpu_rdata  output  32; cpu_pause  output  1  CPU must hold its request.
REQ-006 SHALL have ports: dma_req, dma_write, dma_addr, dma_wdata, dma_size, dma_rdata, dma_pause, with the same directions and widths as the CPU ports.
REQ-007 SHALL have ports: mem_addr, mem_wdata  output  32; mem_size  output  2; mem_write  output  1 (to memory bus port).
REQ-008 SHALL have ports: mem_rdata  input  32; mem_pause  input  1 (from memory bus port).
REQ-009 SHALL have port: owner  output  1  current bus owner, 0 = CPU, 1 = DMA.

Function
REQ-010 SHALL implement states CPU_OWN, DMA_OWN and WR_HOLD, with a registered hold_owner bit recording which requester is holding.
REQ-011 In CPU_OWN/DMA_OWN SHALL drive mem_addr/wdata/size from the owner's inputs, and mem_write = owner_write & owner_req.
REQ-012 In WR_HOLD SHALL keep driving the held owner's addr/size/wdata, with mem_write = 0.
REQ-013 CPU_OWN -> DMA_OWN SHALL occur when dma_req=1 and the CPU is not issuing a write this cycle; handover takes effect the next cycle.
REQ-014 DMA_OWN -> CPU_OWN SHALL occur when dma_req=0 and DMA is not issuing a write this cycle.
REQ-015 Any cycle with mem_write=1 SHALL transition to WR_HOLD and set hold_owner = owner.
REQ-016 WR_HOLD SHALL return to the held owner's state once mem_pause=0; while mem_pause=1 it SHALL stay in WR_HOLD.
REQ-017 Write completion SHALL take priority over a pending arbitration switch; a switch request is evaluated only after WR_HOLD exits.
REQ-018 owner_pause SHALL equal mem_pause | (state==WR_HOLD).
REQ-019 Non-owner pause SHALL equal its req, asserted for every cycle it is requesting but not granted.
REQ-020 Read data SHALL have 1-cycle latency: a registered rd_owner (owner of the previous cycle) selects the destination of mem_rdata.
REQ-021 The requester not selected by rd_owner SHALL receive 32'h0 on its rdata.
REQ-022 Simultaneous cpu_req and dma_req from CPU_OWN with no CPU write SHALL result in a handover to DMA (DMA has priority).
REQ-023 With both requests low, state SHALL remain unchanged and mem_write SHALL be 0.

Reset
REQ-024 On reset assertion the block SHALL immediately enter CPU_OWN with hold_owner=0, rd_owner=0 and the starve counter at 0.
REQ-025 During reset SHALL drive owner=0, mem_write=0, cpu_pause=0, dma_pause=dma_req, and cpu_rdata=dma_rdata=0.
REQ-026 Reset asserted mid-WR_HOLD SHALL abandon the hold; no retry is issued.

Configuration
REQ-027 Macro MEM_ARB_STARVE_GUARD_EN, when defined, SHALL add a 4-bit counter of consecutive DMA_OWN cycles, cleared on any other state.
REQ-028 With the macro defined, when the count reaches 15 and cpu_req=1, SHALL force DMA_OWN -> CPU_OWN for at least one cycle regardless of dma_req, then arbitrate normally.
REQ-029 A DMA write in progress SHALL still complete via WR_HOLD before the forced handover.
REQ-030 With the macro undefined, the counter SHALL be absent and DMA SHALL hold the bus for as long as dma_req=1.

Verification
REQ-031 CPU read at 0x0300_0010, dma_req=0 -> owner=0, mem_addr=0x0300_0010, next-cycle mem_rdata routed to cpu_rdata, dma_rdata=0.
REQ-032 CPU word write to 0x0600_0000, dma_req raised the same cycle -> WR_HOLD for 1 cycle with cpu_pause=1 and dma_pause=1, then owner=1 one cycle after hold exit.
REQ-033 Both requesting from CPU_OWN, no writes -> owner=1 next cycle and cpu_pause=1 every cycle until dma_req falls.
REQ-034 Reset pulsed during a DMA WR_HOLD -> owner=0 and mem_write=0 in the same cycle, with no write replay after release.
REQ-035 MEM_ARB_STARVE_GUARD_EN defined, dma_req and cpu_req held high -> owner=1 for 16 cycles, owner=0 for 1 cycle, then owner=1 again; with the macro undefined -> owner stays 1.
